// File: rtl/mem_block_ctrl.sv
// mem_block_ctrl: block-granular main memory behind the 2-way write-back cache.
// Serves 128-bit refills and write-backs over a req/ack handshake with a fixed
// LATENCY from acceptance to ack. Index is address[9:4], wrapped modulo BLOCKS.
// Optional build macro MEM_BLOCK_CTRL_STATS_EN adds saturating rd_count/wr_count.
module mem_block_ctrl #(
  parameter int LATENCY = 4,
  parameter int BLOCKS  = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         read_write,
  input  logic [9:0]   address,
  input  logic [127:0] writeData,
  output logic         ready,
  output logic         ack,
  output logic [127:0] readData
`ifdef MEM_BLOCK_CTRL_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             nextState;
  logic               accept;
  logic [3:0]         cnt;
  logic               isWrite;
  logic [IDX_W-1:0]   idx;
  logic [127:0]       wrData;
  logic [127:0]       mem [BLOCKS];
  logic [IDX_W-1:0]   reqIdx;
  logic [IDX_W-1:0]   loadIdx;
  logic               loadIsWrite;
  logic               unusedAddrBits;

  // Offset-within-block bits carry no meaning for a block memory.
  assign unusedAddrBits = ^address[3:0];

  // Block index of the incoming request; wraps when BLOCKS is below 64.
  assign reqIdx = IDX_W'({1'b0, address[9:4]} % 7'(BLOCKS));

  // With LATENCY=1 DONE is entered straight from IDLE, so the refill read has
  // to use the live request fields rather than the not-yet-latched copies.
  assign loadIdx     = (state == IDLE) ? reqIdx : idx;
  assign loadIsWrite = (state == IDLE) ? read_write : isWrite;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    nextState = state;
    ready     = 1'b0;
    ack       = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          accept    = 1'b1;
          nextState = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) nextState = DONE;
      end
      DONE: begin
        ack       = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Latency counter: loaded on acceptance, counts down while BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= 4'(LATENCY - 1);
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request direction and index captured at acceptance; cleared so an aborted
  // request cannot be completed later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isWrite <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      isWrite <= read_write;
      idx     <= reqIdx;
    end
  end

  // Write-back payload captured at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) wrData <= writeData;
  end

  // Storage array: cleared on reset, write committed on the edge leaving DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BLOCKS; i++) mem[i] <= '0;
    end else if (state == DONE && isWrite) begin
      mem[idx] <= wrData;
    end
  end

  // Refill data registered on the edge entering DONE and held until next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData <= '0;
    end else if (nextState == DONE && state != DONE && !loadIsWrite) begin
      readData <= mem[loadIdx];
    end
  end

`ifdef MEM_BLOCK_CTRL_STATS_EN
  // Saturating completion counters, bumped once per DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (state == DONE) begin
      if (isWrite) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed bench for mem_block_ctrl (LATENCY=4, BLOCKS=64).
module tb_mem_block_ctrl;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic         read_write;
  logic [9:0]   address;
  logic [127:0] writeData;
  logic         ready;
  logic         ack;
  logic [127:0] readData;
`ifdef MEM_BLOCK_CTRL_STATS_EN
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
`endif

  int checks   = 0;
  int failures = 0;
  int expRd    = 0;
  int expWr    = 0;
  logic [127:0] lastRd = '0;

  localparam logic [127:0] D_FF = 128'h000000000000000000000000000000FF;
  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D_1  = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] D_2  = 128'hDEADBEEFCAFEF00D_1122334455667788;

  mem_block_ctrl #(.LATENCY(LAT), .BLOCKS(64)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .read_write(read_write),
    .address(address),
    .writeData(writeData),
    .ready(ready),
    .ack(ack),
    .readData(readData)
`ifdef MEM_BLOCK_CTRL_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction started from an IDLE cycle; checks ack timing,
  // ready, and refill data. Inputs are scrambled after acceptance.
  task automatic doReq(input logic rw, input logic [9:0] a, input logic [127:0] wd,
                       input logic [127:0] expData, input string tag);
    check({tag, "_rdy_idle"}, {127'd0, ready}, 128'd1);
    req = 1'b1; read_write = rw; address = a; writeData = wd;
    tick();
    req = 1'b0; read_write = ~rw; address = ~a; writeData = ~wd;
    for (int i = 0; i <= LAT; i++) begin
      check({tag, "_ack"},   {127'd0, ack},   {127'd0, (i == LAT)});
      check({tag, "_ready"}, {127'd0, ready}, 128'd0);
      if (i == LAT) begin
        if (!rw) lastRd = expData;
        check({tag, "_data"}, readData, lastRd);
      end
      tick();
    end
    check({tag, "_rdy_after"}, {127'd0, ready}, 128'd1);
    check({tag, "_ack_after"}, {127'd0, ack},   128'd0);
    if (rw) expWr++; else expRd++;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; read_write = 1'b0; address = '0; writeData = '0;
    tick();
    tick();
    check("rst_ready", {127'd0, ready}, 128'd1);
    check("rst_ack",   {127'd0, ack},   128'd0);
    check("rst_data",  readData,        128'd0);
    reset = 1'b0;
    tick();

    doReq(1'b0, 10'h000, '0, 128'd0, "rd0_cold");
    doReq(1'b1, 10'h000, D_FF, '0, "wr0_ff");
    doReq(1'b0, 10'h00C, '0, D_FF, "rd00c");
    doReq(1'b1, 10'h200, D_A5, '0, "wr200");
    doReq(1'b0, 10'h000, '0, D_FF, "rd000");
    doReq(1'b0, 10'h200, '0, D_A5, "rd200");
    doReq(1'b1, 10'h100, D_1, '0, "wr100");
    doReq(1'b1, 10'h300, D_2, '0, "wr300");

    // req held high across two reads; second accepted only once IDLE is reached.
    req = 1'b1; read_write = 1'b0; address = 10'h100;
    tick();
    address = 10'h300;
    for (int i = 0; i <= LAT; i++) begin
      check("hold1_ack", {127'd0, ack}, {127'd0, (i == LAT)});
      if (i == LAT) check("hold1_data", readData, D_1);
      tick();
    end
    check("hold_gap_ready", {127'd0, ready}, 128'd1);
    check("hold_gap_ack",   {127'd0, ack},   128'd0);
    tick();
    req = 1'b0;
    check("hold2_accepted", {127'd0, ready}, 128'd0);
    for (int i = 0; i <= LAT; i++) begin
      check("hold2_ack", {127'd0, ack}, {127'd0, (i == LAT)});
      if (i == LAT) check("hold2_data", readData, D_2);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("hold_no_dup", {127'd0, ack}, 128'd0);
      tick();
    end
    expRd += 2;
    lastRd = D_2;

`ifdef MEM_BLOCK_CTRL_STATS_EN
    check("stats_rd", {112'd0, rd_count}, 128'(expRd));
    check("stats_wr", {112'd0, wr_count}, 128'(expWr));
`endif

    // Reset in the middle of a write to 0x040.
    req = 1'b1; read_write = 1'b1; address = 10'h040; writeData = D_A5;
    tick();
    req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("midrst_ready", {127'd0, ready}, 128'd1);
    check("midrst_ack",   {127'd0, ack},   128'd0);
    check("midrst_data",  readData,        128'd0);
`ifdef MEM_BLOCK_CTRL_STATS_EN
    check("midrst_rdcnt", {112'd0, rd_count}, 128'd0);
    check("midrst_wrcnt", {112'd0, wr_count}, 128'd0);
`endif
    tick();
    reset = 1'b0;
    expRd = 0; expWr = 0; lastRd = '0;
    tick();
    doReq(1'b0, 10'h040, '0, 128'd0, "rd040_after_rst");
    doReq(1'b0, 10'h200, '0, 128'd0, "rd200_after_rst");
`ifdef MEM_BLOCK_CTRL_STATS_EN
    check("stats_rd_post", {112'd0, rd_count}, 128'(expRd));
    check("stats_wr_post", {112'd0, wr_count}, 128'(expWr));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
